mux_rr_sched: RTL

MUX_RR_SCHED -- requirements
Module: mux_rr_sched

---
 rtl/mux_rr_sched_if.sv | 22 ++
 rtl/mux_rr_sched.sv | 82 ++++++++
 2 files changed

// File: rtl/mux_rr_sched_if.sv
// Handshake bundle for the 31-channel round-robin mux scheduler.
// The producer side (requests, data, consumer ready) uses master; the scheduler uses slave.
interface mux_rr_sched_if;
  logic        en;
  logic [30:0] req;
  logic [61:0] in_data;
  logic        out_ready;
  logic [4:0]  sel;
  logic [30:0] grant;
  logic        out_valid;
  logic [1:0]  out_data;

  modport master (
    output en, req, in_data, out_ready,
    input  sel, grant, out_valid, out_data
  );

  modport slave (
    input  en, req, in_data, out_ready,
    output sel, grant, out_valid, out_data
  );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin 31:1 mux with registered grant and data; a grant appears 1 cycle after the request edge.
// While out_ready is low the held transfer is frozen; a handshake with pending requests regrants back-to-back.
module mux_rr_sched (
  input  logic          clk,
  input  logic          reset,
  mux_rr_sched_if.slave bus
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  sel_q, sel_d;
  logic [30:0] grant_q, grant_d;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  out_data_q, out_data_d;

  logic [4:0]  winner;
  logic        found;
  logic [5:0]  idx;
  logic        take;

  // Scan channels starting at ptr, wrapping past 30 back to 0; first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 31; k++) begin
      idx = {1'b0, ptr_q} + 6'(k);
      if (idx >= 6'd31) idx = idx - 6'd31;
      if (!found && bus.req[idx[4:0]]) begin
        winner = idx[4:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    // A new arbitration happens from IDLE, or from HOLD once the consumer takes the word.
    take = (state_q == IDLE) || bus.out_ready;
    if (take && bus.en && found) begin
      state_d     = HOLD;
      sel_d       = winner;
      grant_d     = 31'd1 << winner;
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[{winner, 1'b0} +: 2];
      ptr_d       = (winner == 5'd30) ? 5'd0 : winner + 5'd1;
    end else if (state_q == HOLD && bus.out_ready) begin
      state_d     = IDLE;
      grant_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule
